seq_mult: RTL and testbench
===========================

# seq_mult

Parametrised sequential shift-add multiplier for the processor's ALU multiply path. It replaces the fixed 8-bit combinational array with a radix-2 iterative datapath that:
- handles a configurable operand width;
- supports unsigned or two's-complement multiplication, selected per operation;
- returns the full double-width product plus an overflow flag for the truncated single-width result.

It sits beside the ALU and uses a START/BUSY/DONE handshake, so the control unit stalls the pipeline while the multiply is in progress.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- SIGNED_EN, 1, when 0 the SIGNED input is ignored and all operations are unsigned.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request a multiply; sampled only in IDLE.
- SIGNED  input  1  1 = two's-complement operands (requires SIGNED_EN=1); sampled with START.
- DATA1  input  WIDTH  multiplicand; sampled with START.
- DATA2  input  WIDTH  multiplier; sampled with START.
- BUSY  output  1  high while in RUN.
- DONE  output  1  one-cycle pulse: RESULT and OVERFLOW are valid and newly updated.
- RESULT  output  2*WIDTH  full product, registered.
- OVERFLOW  output  1  truncated product RESULT[WIDTH-1:0] does not equal the true product, registered.

## Operation
- The FSM has three states.
  - IDLE: START=1 is accepted and the FSM moves to RUN; otherwise it stays in IDLE.
  - RUN: lasts exactly WIDTH cycles; the FSM then moves to DONE.
  - DONE: lasts one cycle; the FSM then moves to IDLE unconditionally.
- START is ignored in RUN and DONE; it has no queueing and no effect.
- On acceptance, the block latches the operand magnitudes, the sign, and the mode, and clears the accumulator and the bit counter.
  - Signed mode (SIGNED & SIGNED_EN): each operand is replaced by its absolute value, and neg = DATA1[MSB] ^ DATA2[MSB] is stored.
  - The absolute value of the most-negative operand (e.g. -128 → 128) fits in WIDTH unsigned bits, so no special case is needed.
  - Unsigned mode: neg = 0.
- Each RUN cycle:
  - if the multiplier LSB is 1, add the multiplicand to the upper half of the 2*WIDTH accumulator, keeping the carry;
  - shift the accumulator and the multiplier right by one;
  - increment the counter.
- On the final RUN edge, RESULT is loaded with neg ? -acc : acc, where acc is the post-update accumulator value, and OVERFLOW is loaded at the same time.
- OVERFLOW rule:
  - unsigned: OVERFLOW = (RESULT[2W-1:W] != 0);
  - signed: OVERFLOW = (RESULT[2W-1:W] != {W{RESULT[W-1]}}).
- RESULT and OVERFLOW hold their values until the next completion; they do not change in IDLE or RUN.
- Latency is fixed and data-independent; there is no early termination.

## Timing
- Reset values: state IDLE, BUSY=0, DONE=0, RESULT=0, OVERFLOW=0; the accumulator and counter are cleared.
- Let the accept edge be E0, the rising edge where START=1 is sampled in IDLE.
  - BUSY is high from E0 to E_WIDTH.
  - RESULT and OVERFLOW update at E_WIDTH.
  - DONE is high for the single cycle from E_WIDTH to E_WIDTH+1.
  - The next START can be accepted at E_WIDTH+2 at the earliest.
  - Issue-to-issue interval is WIDTH+2 cycles.
- RESET is asserted mid-operation (RUN or DONE): the next edge forces all reset values.
  - No DONE pulse is produced, and RESULT returns to 0.
- START and RESET sampled high together: RESET wins and the request is dropped.
- Operand inputs may change freely after E0 without affecting the result.

## Test plan
- WIDTH=8, unsigned, 13×11 → RESULT=0x008F, OVERFLOW=0; DONE high exactly in the cycle following E8; BUSY high for 8 cycles.
- WIDTH=8, unsigned, 255×255 → RESULT=0xFE01, OVERFLOW=1; 0×200 → RESULT=0x0000, OVERFLOW=0.
- WIDTH=8, signed:
  - (-3)×5 → RESULT=0xFFF1, OVERFLOW=0;
  - (-128)×(-128) → RESULT=0x4000, OVERFLOW=1;
  - (-128)×1 → RESULT=0xFF80, OVERFLOW=0.
- Handshake:
  - a START pulse at E3 of an operation, and one during the DONE cycle, are both ignored (one DONE pulse only, RESULT from the first operands);
  - START held high continuously → a new accept every 10 cycles.
- RESET asserted at E4 of a running multiply → next cycle BUSY=0, DONE=0, RESULT=0; no DONE pulse ever appears for that operation.
- WIDTH=16, SIGNED_EN=0 and 1: 1000 random operand pairs and modes checked against a reference product and overflow; additionally, SIGNED=1 with SIGNED_EN=0 gives unsigned results.

Source files
------------

// File: rtl/seq_mult.sv
// Radix-2 iterative shift-add multiplier with START/BUSY/DONE handshake.
// Produces a full double-width product and a single-width overflow flag.
module seq_mult #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic               SIGNED,
  input  logic [WIDTH-1:0]   DATA1,
  input  logic [WIDTH-1:0]   DATA2,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] RESULT,
  output logic               OVERFLOW
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 sgn_q, sgn_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ovf_q, ovf_d;

  logic                 signed_op;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     prod_hi;

  // Datapath for one RUN step; the carry out of the upper half is kept.
  always_comb begin
    signed_op = SIGNED_EN && SIGNED;
    addend    = mplier_q[0] ? mcand_q : '0;
    sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    acc_step  = (2*WIDTH)'({sum, acc_q[WIDTH-1:0]} >> 1);
    prod      = neg_q ? -acc_step : acc_step;
    prod_hi   = prod[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    sgn_d    = sgn_q;
    result_d = result_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d  = StRun;
          // Negating the most-negative value still yields the right unsigned magnitude.
          mcand_d  = (signed_op && DATA1[WIDTH-1]) ? -DATA1 : DATA1;
          mplier_d = (signed_op && DATA2[WIDTH-1]) ? -DATA2 : DATA2;
          neg_d    = signed_op && (DATA1[WIDTH-1] ^ DATA2[WIDTH-1]);
          sgn_d    = signed_op;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      StRun: begin
        acc_d    = acc_step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d  = StDone;
          result_d = prod;
          ovf_d    = sgn_q ? (prod_hi != {WIDTH{prod[WIDTH-1]}}) : (prod_hi != '0);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      sgn_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      sgn_q    <= sgn_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign BUSY     = (state_q == StRun);
  assign DONE     = (state_q == StDone);
  assign RESULT   = result_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult: 8-bit directed/handshake tests and a 16-bit
// sweep against a behavioural product model with SIGNED_EN set and cleared.
module tb_seq_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, sgn8, busy8, done8, ovf8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        start16, sgn16;
  logic [15:0] a16, b16;
  logic        busy16s, done16s, ovf16s, busy16u, done16u, ovf16u;
  logic [31:0] res16s, res16u;

  int n_cmp = 0;
  int n_err = 0;

  logic [16:0] q8[$];
  logic [32:0] q16s[$];
  logic [32:0] q16u[$];

  seq_mult #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut8 (
    .CLK(clk), .RESET(rst), .START(start8), .SIGNED(sgn8), .DATA1(a8), .DATA2(b8),
    .BUSY(busy8), .DONE(done8), .RESULT(res8), .OVERFLOW(ovf8)
  );

  seq_mult #(.WIDTH(16), .SIGNED_EN(1'b1)) u_dut16s (
    .CLK(clk), .RESET(rst), .START(start16), .SIGNED(sgn16), .DATA1(a16), .DATA2(b16),
    .BUSY(busy16s), .DONE(done16s), .RESULT(res16s), .OVERFLOW(ovf16s)
  );

  seq_mult #(.WIDTH(16), .SIGNED_EN(1'b0)) u_dut16u (
    .CLK(clk), .RESET(rst), .START(start16), .SIGNED(sgn16), .DATA1(a16), .DATA2(b16),
    .BUSY(busy16u), .DONE(done16u), .RESULT(res16u), .OVERFLOW(ovf16u)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] ref16(input logic s, input logic [15:0] a,
                                        input logic [15:0] b);
    logic signed [31:0] ps;
    logic [31:0]        pu;
    if (s) begin
      ps = $signed(a) * $signed(b);
      return {ps, ps[31:16] != {16{ps[15]}}};
    end
    pu = {16'b0, a} * {16'b0, b};
    return {pu, pu[31:16] != 16'h0000};
  endfunction

  // Monitors: pop an expected response whenever a DONE pulse is presented.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) check("dut8 spurious DONE", {63'b0, done8}, 64'd0);
      else begin
        logic [16:0] e;
        e = q8.pop_front();
        check("dut8 RESULT", {48'b0, res8}, {48'b0, e[16:1]});
        check("dut8 OVERFLOW", {63'b0, ovf8}, {63'b0, e[0]});
      end
    end
  end

  always @(negedge clk) begin
    if (done16s === 1'b1) begin
      if (q16s.size() == 0) check("dut16s spurious DONE", {63'b0, done16s}, 64'd0);
      else begin
        logic [32:0] e;
        e = q16s.pop_front();
        check("dut16s RESULT", {32'b0, res16s}, {32'b0, e[32:1]});
        check("dut16s OVERFLOW", {63'b0, ovf16s}, {63'b0, e[0]});
      end
    end
  end

  always @(negedge clk) begin
    if (done16u === 1'b1) begin
      if (q16u.size() == 0) check("dut16u spurious DONE", {63'b0, done16u}, 64'd0);
      else begin
        logic [32:0] e;
        e = q16u.pop_front();
        check("dut16u RESULT", {32'b0, res16u}, {32'b0, e[32:1]});
        check("dut16u OVERFLOW", {63'b0, ovf16u}, {63'b0, e[0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle8();
    int guard = 0;
    while ((busy8 || done8) && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check("dut8 idle timeout", {63'b0, busy8}, 64'd0);
  endtask

  task automatic issue8(input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] er, input logic eo);
    wait_idle8();
    sgn8   = s;
    a8     = a;
    b8     = b;
    start8 = 1'b1;
    q8.push_back({er, eo});
    tick();
    start8 = 1'b0;
    a8     = ~a;
    b8     = b ^ 8'h5A;
    check("dut8 BUSY after accept", {63'b0, busy8}, 64'd1);
  endtask

  initial begin
    int n;
    int guard;
    int rises;
    int last;
    int cyc;
    logic prev;
    logic [15:0] ra, rb;
    logic rs;

    rst = 1'b1; start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0;
    tick();
    tick();
    check("reset BUSY", {63'b0, busy8}, 64'd0);
    check("reset DONE", {63'b0, done8}, 64'd0);
    check("reset RESULT", {48'b0, res8}, 64'd0);
    check("reset OVERFLOW", {63'b0, ovf8}, 64'd0);
    rst = 1'b0;
    tick();

    // 13 x 11 with cycle-accurate BUSY/DONE timing.
    issue8(1'b0, 8'd13, 8'd11, 16'h008F, 1'b0);
    n = 1;
    while (busy8 && n < 20) begin
      tick();
      if (busy8) n++;
    end
    check("BUSY cycle count", 64'(n), 64'd8);
    check("DONE after E8", {63'b0, done8}, 64'd1);
    tick();
    check("DONE single pulse", {63'b0, done8}, 64'd0);

    issue8(1'b0, 8'd255, 8'd255, 16'hFE01, 1'b1);
    issue8(1'b0, 8'd0, 8'd200, 16'h0000, 1'b0);
    issue8(1'b1, 8'hFD, 8'd5, 16'hFFF1, 1'b0);
    issue8(1'b1, 8'h80, 8'h80, 16'h4000, 1'b1);
    issue8(1'b1, 8'h80, 8'h01, 16'hFF80, 1'b0);

    // START at E3 and during DONE must be ignored.
    issue8(1'b0, 8'd7, 8'd9, 16'h003F, 1'b0);
    tick();
    tick();
    start8 = 1'b1; a8 = 8'd2; b8 = 8'd2;
    tick();
    start8 = 1'b0;
    guard = 0;
    while (!done8 && guard < 20) begin
      tick();
      guard++;
    end
    check("DONE reached", {63'b0, done8}, 64'd1);
    start8 = 1'b1; a8 = 8'd3; b8 = 8'd3;
    tick();
    start8 = 1'b0;
    n = 0;
    repeat (12) begin
      tick();
      if (busy8) n++;
    end
    check("ignored STARTs cause no run", 64'(n), 64'd0);

    // START held high: one accept every WIDTH+2 cycles.
    wait_idle8();
    sgn8 = 1'b0; a8 = 8'd3; b8 = 8'd4;
    repeat (3) q8.push_back({16'd12, 1'b0});
    start8 = 1'b1;
    rises = 0; last = 0; cyc = 0; prev = busy8;
    while (rises < 3 && cyc < 60) begin
      tick();
      cyc++;
      if (busy8 && !prev) begin
        if (rises > 0) check("held START accept interval", 64'(cyc - last), 64'd10);
        last = cyc;
        rises++;
        if (rises == 3) start8 = 1'b0;
      end
      prev = busy8;
    end
    start8 = 1'b0;
    check("held START accepts", 64'(rises), 64'd3);

    // Reset sampled at E4 of a running multiply.
    wait_idle8();
    sgn8 = 1'b0; a8 = 8'd100; b8 = 8'd100; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-run reset BUSY", {63'b0, busy8}, 64'd0);
    check("mid-run reset DONE", {63'b0, done8}, 64'd0);
    check("mid-run reset RESULT", {48'b0, res8}, 64'd0);
    n = 0;
    repeat (15) begin
      tick();
      if (busy8) n++;
    end
    check("no run after reset", 64'(n), 64'd0);

    // START and RESET together: request dropped.
    rst = 1'b1; start8 = 1'b1; a8 = 8'd5; b8 = 8'd5;
    tick();
    rst = 1'b0; start8 = 1'b0;
    check("START dropped under RESET", {63'b0, busy8}, 64'd0);

    // 16-bit sweep: corner vectors first, then pseudo-random pairs and modes.
    for (int i = 0; i < 1000; i++) begin
      case (i)
        0: begin ra = 16'h8000; rb = 16'h8000; rs = 1'b1; end
        1: begin ra = 16'hFFFF; rb = 16'hFFFF; rs = 1'b0; end
        2: begin ra = 16'hFFFF; rb = 16'hFFFF; rs = 1'b1; end
        3: begin ra = 16'h8000; rb = 16'h0001; rs = 1'b1; end
        default: begin
          ra = 16'($urandom);
          rb = 16'($urandom);
          rs = 1'($urandom);
        end
      endcase
      guard = 0;
      while ((busy16s || done16s || busy16u || done16u) && guard < 100) begin
        tick();
        guard++;
      end
      if (guard >= 100) check("dut16 idle timeout", {63'b0, busy16s}, 64'd0);
      sgn16 = rs; a16 = ra; b16 = rb; start16 = 1'b1;
      q16s.push_back(ref16(rs, ra, rb));
      q16u.push_back(ref16(1'b0, ra, rb));
      tick();
      start16 = 1'b0;
      a16 = 16'($urandom);
      b16 = 16'($urandom);
    end

    guard = 0;
    while ((q8.size() != 0 || q16s.size() != 0 || q16u.size() != 0) && guard < 100) begin
      tick();
      guard++;
    end
    check("dut8 outstanding", 64'(q8.size()), 64'd0);
    check("dut16s outstanding", 64'(q16s.size()), 64'd0);
    check("dut16u outstanding", 64'(q16u.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
